// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and a local access port.
// SCL/SDA are synchronized; every protocol action happens on a detected SCL edge or START/STOP.
module i2c_slave_regs #(
  parameter logic [6:0]  I2C_ADR   = 7'b0010_000,
  parameter int unsigned MEM_DEPTH = 4,
  parameter int unsigned AW        = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          scl_pad_i,
  output logic          scl_pad_o,
  output logic          scl_padoen_o,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  input  logic [AW-1:0] loc_adr_i,
  input  logic [7:0]    loc_dat_i,
  input  logic          loc_we_i,
  output logic [7:0]    loc_dat_o,
  output logic          wr_stb_o,
  output logic [AW-1:0] wr_adr_o,
  output logic          busy_o
);

  typedef enum logic [3:0] {
    StIdle,
    StDevAdr,
    StDevAck,
    StMemAdr,
    StWrAck,
    StWrData,
    StRdData,
    StRdAck,
    StIgnore
  } state_e;

  state_e        state;
  logic          scl_meta, scl_sync, scl_hist;
  logic          sda_meta, sda_sync, sda_hist;
  logic          scl_rise, scl_fall, scl_high;
  logic          start_det, stop_det;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;
  logic          rw;
  logic          mack;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_inc;
  logic          adr_ok;
  logic          i2c_wr;
  logic [7:0]    mem [MEM_DEPTH];

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl_pad_i;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda_pad_i;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_hist;
  assign scl_fall  = ~scl_sync & scl_hist;
  assign scl_high  = scl_sync & scl_hist;
  assign start_det = scl_high & sda_hist & ~sda_sync;
  assign stop_det  = scl_high & ~sda_hist & sda_sync;

  assign ptr_inc = ptr + AW'(1);
  assign adr_ok  = ({24'd0, shreg} < MEM_DEPTH);
  assign i2c_wr  = (state == StWrData) && scl_fall && (bit_cnt == 4'd8) && !start_det && !stop_det;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= StIdle;
      ptr          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      rw           <= 1'b0;
      mack         <= 1'b1;
      sda_padoen_o <= 1'b1;
      wr_stb_o     <= 1'b0;
      wr_adr_o     <= '0;
      busy_o       <= 1'b0;
    end else begin
      wr_stb_o <= 1'b0;
      if (stop_det) begin
        state        <= StIdle;
        sda_padoen_o <= 1'b1;
        busy_o       <= 1'b0;
      end else if (start_det) begin
        state        <= StDevAdr;
        sda_padoen_o <= 1'b1;
        busy_o       <= 1'b0;
        bit_cnt      <= '0;
      end else begin
        unique case (state)
          StIdle: sda_padoen_o <= 1'b1;
          StDevAdr: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_sync};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shreg[7:1] == I2C_ADR) begin
                rw           <= shreg[0];
                sda_padoen_o <= 1'b0;
                busy_o       <= 1'b1;
                state        <= StDevAck;
              end else begin
                state <= StIgnore;
              end
            end
          end
          // ACK is held low until the fall that ends the 9th clock.
          StDevAck: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              bit_cnt <= '0;
              if (!rw) begin
                sda_padoen_o <= 1'b1;
                state        <= StMemAdr;
              end else begin
                shreg        <= mem[ptr];
                sda_padoen_o <= mem[ptr][7];
                state        <= StRdData;
              end
            end
          end
          StMemAdr: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_sync};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (adr_ok) begin
                ptr          <= shreg[AW-1:0];
                sda_padoen_o <= 1'b0;
                state        <= StWrAck;
              end else begin
                state <= StIgnore;
              end
            end
          end
          StWrAck: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              bit_cnt      <= '0;
              sda_padoen_o <= 1'b1;
              state        <= StWrData;
            end
          end
          StWrData: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_sync};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt      <= '0;
              wr_stb_o     <= 1'b1;
              wr_adr_o     <= ptr;
              ptr          <= ptr_inc;
              sda_padoen_o <= 1'b0;
              state        <= StWrAck;
            end
          end
          // Bit 7 is already on the bus at entry; each later fall shifts out the next bit.
          StRdData: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt      <= '0;
                sda_padoen_o <= 1'b1;
                state        <= StRdAck;
              end else begin
                shreg        <= {shreg[6:0], 1'b0};
                sda_padoen_o <= shreg[6];
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              mack    <= sda_sync;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              bit_cnt <= '0;
              if (!mack) begin
                ptr          <= ptr_inc;
                shreg        <= mem[ptr_inc];
                sda_padoen_o <= mem[ptr_inc][7];
                state        <= StRdData;
              end else begin
                state <= StIgnore;
              end
            end
          end
          StIgnore: sda_padoen_o <= 1'b1;
          default: begin
            state        <= StIdle;
            sda_padoen_o <= 1'b1;
          end
        endcase
      end
    end
  end

  // An I2C write in the same cycle suppresses the local write entirely.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem       <= '{default: '0};
      loc_dat_o <= '0;
    end else begin
      loc_dat_o <= mem[loc_adr_i];
      if (i2c_wr) begin
        mem[ptr] <= shreg;
      end else if (loc_we_i) begin
        mem[loc_adr_i] <= loc_dat_i;
      end
    end
  end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

Synthesizable I2C target (slave) that answers the WISHBONE I2C master core on the same SCL/SDA bus and exposes a small byte-wide register file. It decodes START/STOP, matches a 7-bit device address, takes a memory-address byte, then writes or reads consecutive registers with auto-increment. A local single-cycle port gives on-chip logic read/write access to the same registers. It replaces the behavioural slave model in system benches and ships in silicon.

## Interface
- I2C_ADR, 7'b0010_000, 7-bit device address this target answers
- MEM_DEPTH, 4, number of 8-bit registers (power of 2, 2..256)
- AW, 2, register index width, log2(MEM_DEPTH)
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- scl_pad_i  in  1  SCL from pad (asynchronous)
- scl_pad_o  out  1  constant 0
- scl_padoen_o  out  1  constant 1 (no clock stretching)
- sda_pad_i  in  1  SDA from pad (asynchronous)
- sda_pad_o  out  1  constant 0
- sda_padoen_o  out  1  0 = pull SDA low, 1 = release
- loc_adr_i  in  AW  local register index
- loc_dat_i  in  8  local write data
- loc_we_i  in  1  local write enable, one cycle
- loc_dat_o  out  8  registered mem[loc_adr_i], one-cycle latency
- wr_stb_o  out  1  one-cycle pulse when an I2C data byte is written
- wr_adr_o  out  AW  index written on wr_stb_o
- busy_o  out  1  high from address match until STOP/START/idle

## Operation
- SCL/SDA pass through a 2-FF synchronizer, then a history FF; edges are detected on synchronized values.
- START: SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high. Both are detected in every state; STOP -> IDLE, START -> DEV_ADR (repeated start allowed); both release SDA.
- Data bits are sampled on SCL rising edge, MSB first. SDA is changed only on SCL falling edge.
- States:
  - IDLE: SDA released, busy_o=0.
  - DEV_ADR: shift 8 bits. At the falling edge after bit 8: match {I2C_ADR} -> DEV_ACK (drive low); mismatch -> IGNORE.
  - DEV_ACK: at the falling edge after the 9th clock, R/W=0 -> MEM_ADR (release); R/W=1 -> load mem[ptr] into the shifter, drive bit 7, go to RD_DATA.
  - MEM_ADR: shift 8 bits. At the falling edge after bit 8: value < MEM_DEPTH -> ptr=value, ACK, then WR_DATA; else no ACK -> IGNORE.
  - WR_DATA: shift 8 bits. At the falling edge after bit 8: mem[ptr]=byte, wr_stb_o pulse with wr_adr_o=ptr, ptr=ptr+1 mod MEM_DEPTH, ACK, remain in WR_DATA.
  - RD_DATA: drive bits 7..0. After bit 0, release SDA and sample the master's ACK on the 9th rising edge. ACK (0): ptr++ mod MEM_DEPTH, load the next byte, drive at the 9th falling edge. NACK (1): IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- ptr persists across transactions (read without memory address continues from the last ptr). Reset clears ptr to 0.
- Local port write and I2C write in the same cycle: the I2C write wins; the local write is dropped.
- The local read returns pre-write data in a same-cycle collision.

## Timing
- Reset (synchronous): state IDLE, ptr 0, all mem 0, sda_padoen_o=1, wr_stb_o=0, wr_adr_o=0, busy_o=0, loc_dat_o=0, synchronizers to 1.
- Reset mid-transfer: SDA released on the next clock; the target rejoins only at the next START.
- Pad edge to detected edge: 2 clocks. sda_padoen_o updates 3 clocks after the SCL pad falling edge.
- Constraint: the SCL low and high periods are each at least 6 wb_clk_i cycles.
- ACK drive is held from the falling edge after bit 8 until the falling edge after the 9th clock.
- wr_stb_o asserts in the same cycle the register is updated, for exactly 1 clock.

## Test plan
- Write: START, 0x20, 0x01, 0xA5, 0x5A, STOP. Required: all four bytes ACKed; mem[1]=A5, mem[2]=5A; wr_stb_o pulses with wr_adr_o=1 then 2.
- Combined read: START 0x20, 0x01, repeated START 0x21, read with ACK, ACK, NACK. Required: master receives A5, 5A, 00; then STOP leaves busy_o=0.
- Invalid address: START 0x20, 0x10. Required: device address ACKed, memory address NACKed (SDA high on the 9th clock); later bytes ignored until STOP.
- Wrong device: START 0x22. Required: SDA never driven low; busy_o stays 0.
- Wrap: write to 0x03 with bytes 11, 22. Required: mem[3]=11, mem[0]=22. A local write to index 0 in the same cycle as the I2C write is dropped.
- Reset mid-read: assert wb_rst_i while driving a 0 bit. Required: sda_padoen_o=1 next clock, mem cleared, and the next START/0x20 is ACKed normally.
